uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial UART receiver; consumes mid-bit sample strobe of uart_baudgen RX channel and drives its counter-hold input.
//  Synchronises i_rx, detects start edge, samples start/data/[parity]/stop bits, presents byte on valid/ready port.
//  Sits between pad input and AXI4-Lite register block RX data/status registers.
// PARAMETERS
//  DATA_BITS    8   data bits per frame, legal 5..8; LSB first; o_data upper unused bits = 0
//  SYNC_STAGES  2   flops in i_rx synchroniser, legal >= 2
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          synchronous, active-low reset
//  i_rx           in   1          asynchronous serial line, idle high
//  i_rx_strb      in   1          mid-bit sample strobe from baudgen (o_rx_strb)
//  o_rx_strb_en   out  1          to baudgen i_rx_strb_en; 1 = hold RX counter at 0
//  i_parity_odd   in   1          1 = odd, 0 = even parity (used only with UART_RX_PARITY_EN)
//  o_data         out  8          received byte, valid when o_valid
//  o_valid        out  1          holding register full
//  i_ready        in   1          consumer accepts o_data when o_valid & i_ready
//  o_frame_err    out  1          stop bit sampled 0 for held byte; qualified by o_valid
//  o_parity_err   out  1          parity mismatch for held byte; qualified by o_valid; tied 0 without macro
//  o_overrun      out  1          sticky: frame completed while holding register full
//  i_clr_overrun  in   1          clears o_overrun
//  o_busy         out  1          1 whenever FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, sync flops and rx_prev = 1, o_rx_strb_en=1, o_data=0, o_valid=0, all error flags 0, o_busy=0.
//  o_rx_strb_en = 1 exactly when FSM in IDLE (registered, no combinational path from i_rx).
//  FSM IDLE -> START: synchronised rx_prev==1 and rx==0 (falling edge); level-low alone never triggers (break safe).
//  Start edge visible SYNC_STAGES+1 cycles after i_rx falls; baudgen counter released next cycle, first strobe at half bit.
//  START on i_rx_strb: rx==0 -> DATA, bit_cnt=0; rx==1 -> IDLE (glitch rejected, nothing reported).
//  DATA on i_rx_strb: shift rx into MSB side of DATA_BITS shifter (LSB first); after DATA_BITS strobes -> PARITY or STOP.
//  PARITY (macro only) on i_rx_strb: perr = (^data ^ rx) != i_parity_odd; -> STOP.
//  STOP on i_rx_strb: ferr = ~rx; -> IDLE; completion event raised same cycle.
//  Completion: register loads o_data/o_frame_err/o_parity_err, o_valid=1 on next cycle, if o_valid==0 or i_ready==1 that cycle.
//  Completion with o_valid=1 and i_ready=0: new byte dropped, held byte kept, o_overrun<=1.
//  o_valid & i_ready without completion: o_valid<=0 next cycle; o_data unchanged.
//  i_clr_overrun and new overrun same cycle: set wins.
//  i_rx_strb ignored in IDLE; strobes only counted in START/DATA/PARITY/STOP.
//  Frame with ferr still delivered (data as sampled). After STOP with rx low, IDLE waits for rx high then a new edge.
//  Reset mid-frame: immediate return to reset values; partial frame discarded, no completion.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, one parity bit after data, i_parity_odd selects sense.
//  UART_RX_PARITY_EN undefined: DATA -> STOP directly, o_parity_err constant 0, i_parity_odd unused.
// TESTING (bench: uart_baudgen CLK_FREQ=100000000, i_baud_rate=3'b100, strobe period 869 clk, 8 data bits)
//  1. Send 0xA5 8N1, i_ready=1 -> one o_valid pulse, o_data=0xA5, frame/parity/overrun=0; o_rx_strb_en=1 after.
//  2. Pull i_rx low 100 clk then high -> no o_valid, FSM back to IDLE after first strobe, o_busy drops.
//  3. Send 0x3C with stop bit 0 -> o_data=0x3C, o_frame_err=1; next frame 0x3C good -> o_frame_err=0.
//  4. i_ready=0, send 0x11 then 0x22 -> o_data=0x11, o_overrun=1; pulse i_clr_overrun -> o_overrun=0, o_data still 0x11.
//  5. Macro on, i_parity_odd=0, send 0x07 with parity bit 0 -> o_parity_err=1; parity bit 1 -> o_parity_err=0.
//  6. Assert rst_n=0 after 4th data bit of 0xFF -> reset values, no o_valid; then send 0x5A -> o_data=0x5A clean.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, detects the start edge, samples
// start/data/[parity]/stop on the baud generator's mid-bit strobe and presents
// the byte in a one-deep holding register with a valid/ready handshake.
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit after the data.
module uart_rx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    input  logic       i_rx_strb,
    output logic       o_rx_strb_en,
    input  logic       i_parity_odd,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overrun,
    input  logic       i_clr_overrun,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rx;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   complete;

    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

`ifdef UART_RX_PARITY_EN
    logic                   perr_q, perr_d;    // parity result of frame in flight
    logic                   hperr_q, hperr_d;  // parity flag of held byte
`else
    logic                   unused_parity_odd;
    assign unused_parity_odd = i_parity_odd;
`endif

    assign rx = sync_q[SYNC_STAGES-1];

    // Line synchroniser and edge-detect history; idle-high after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_rx};
            rx_prev_q <= rx;
        end
    end

    // Frame FSM and data shifter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic; strobes only matter once a start edge has been seen.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        complete  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Falling edge only, so a held-low (break) line never retriggers.
                if (rx_prev_q && !rx) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (i_rx_strb) begin
                    if (!rx) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        perr_d    = 1'b0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (i_rx_strb) begin
                    // LSB first: each new bit enters at the top and walks down.
                    shift_d = {rx, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (i_rx_strb) begin
                    perr_d  = ((^shift_q) ^ rx) != i_parity_odd;
                    state_d = StStop;
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                if (i_rx_strb) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            hperr_q <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            hperr_q <= hperr_d;
`endif
        end
    end

    // Load on completion if the slot is free or being drained this cycle;
    // otherwise drop the new byte and flag overrun (set beats clear).
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
        hperr_d = hperr_q;
`endif
        if (i_clr_overrun) begin
            ovr_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || i_ready) begin
                data_d                  = '0;
                data_d[DATA_BITS-1:0]   = shift_q;
                ferr_d                  = ~rx;
                valid_d                 = 1'b1;
`ifdef UART_RX_PARITY_EN
                hperr_d                 = perr_q;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    assign o_rx_strb_en = (state_q == StIdle);
    assign o_busy       = (state_q != StIdle);
    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = hperr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
